snr_gate_controller: RTL

Consumes the per-sample SNR stream produced by the SNR calculator and turns it into a debounced voice-activity gate for the pitch-detect path. It also owns the SNR calculator's `quiet_period` input:
- it runs a noise-calibration window after reset;
- it runs further windows on request or periodically while no signal is present.

Gate transitions are emitted as events on a single-entry valid/ready output.

---
 rtl/snr_gate_controller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/snr_gate_controller.sv
// Debounced voice-activity gate driven by the SNR stream; owns the noise-calibration window.
// Optional automatic recalibration from CLOSED is enabled by defining SNR_GATE_AUTO_RECAL_EN.
module snr_gate_controller #(
  parameter int SNR_WIDTH     = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int CAL_SAMPLES   = 4096,
  parameter int ON_THRESH_DB  = 12,
  parameter int OFF_THRESH_DB = 6,
  parameter int MIN_RMS       = 64,
  parameter int HOLD_SAMPLES  = 2048,
  parameter int RECAL_SAMPLES = 480000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SNR_WIDTH-1:0]  snr_db,
  input  logic [DATA_WIDTH-1:0] signal_rms,
  input  logic                  snr_valid,
  output logic                  snr_ready,
  input  logic                  start_cal,
  output logic                  quiet_period,
  output logic                  calibrated,
  output logic                  gate_open,
  output logic                  gate_event,
  output logic                  gate_valid,
  input  logic                  gate_ready
);

  localparam int CAL_W  = $clog2(CAL_SAMPLES + 1);
  localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);

  localparam logic signed [SNR_WIDTH-1:0] ON_TH   = SNR_WIDTH'(ON_THRESH_DB);
  localparam logic signed [SNR_WIDTH-1:0] OFF_TH  = SNR_WIDTH'(OFF_THRESH_DB);
  localparam logic [DATA_WIDTH-1:0]       RMS_MIN = DATA_WIDTH'(MIN_RMS);
  localparam logic [CAL_W-1:0]            CAL_LAST  = CAL_W'(CAL_SAMPLES - 1);
  localparam logic [HOLD_W-1:0]           HOLD_LAST = HOLD_W'(HOLD_SAMPLES - 1);

  typedef enum logic [1:0] {S_CAL, S_CLOSED, S_OPEN, S_HOLD} state_t;

  state_t             state, state_nxt;
  logic [CAL_W-1:0]   cal_cnt, cal_cnt_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_nxt;
  logic               s, open_cond, close_cond;
  logic               gate_open_nxt, quiet_nxt, calibrated_nxt;
  logic               gate_event_nxt, gate_valid_nxt;

`ifdef SNR_GATE_AUTO_RECAL_EN
  localparam int RECAL_W = $clog2(RECAL_SAMPLES + 1);
  localparam logic [RECAL_W-1:0] RECAL_LAST = RECAL_W'(RECAL_SAMPLES - 1);
  logic [RECAL_W-1:0] recal_cnt, recal_cnt_nxt;
`endif

  assign snr_ready  = 1'b1;
  assign s          = snr_valid & snr_ready;
  assign open_cond  = ($signed(snr_db) >= ON_TH) && (signal_rms >= RMS_MIN);
  assign close_cond = $signed(snr_db) < OFF_TH;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_CAL;
      cal_cnt      <= '0;
      hold_cnt     <= '0;
      quiet_period <= 1'b1;
      calibrated   <= 1'b0;
      gate_open    <= 1'b0;
      gate_event   <= 1'b0;
      gate_valid   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cal_cnt      <= cal_cnt_nxt;
      hold_cnt     <= hold_cnt_nxt;
      quiet_period <= quiet_nxt;
      calibrated   <= calibrated_nxt;
      gate_open    <= gate_open_nxt;
      gate_event   <= gate_event_nxt;
      gate_valid   <= gate_valid_nxt;
    end
  end

`ifdef SNR_GATE_AUTO_RECAL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) recal_cnt <= '0;
    else        recal_cnt <= recal_cnt_nxt;
  end
`endif

  always_comb begin
    state_nxt    = state;
    cal_cnt_nxt  = cal_cnt;
    hold_cnt_nxt = hold_cnt;
`ifdef SNR_GATE_AUTO_RECAL_EN
    recal_cnt_nxt = recal_cnt;
`endif
    if (start_cal) begin
      state_nxt = S_CAL;
    end else if (s) begin
      case (state)
        S_CAL: begin
          if (cal_cnt == CAL_LAST) state_nxt = S_CLOSED;
          else                     cal_cnt_nxt = cal_cnt + CAL_W'(1);
        end
        S_CLOSED: begin
          if (open_cond) state_nxt = S_OPEN;
`ifdef SNR_GATE_AUTO_RECAL_EN
          else if (recal_cnt == RECAL_LAST) state_nxt = S_CAL;
          else recal_cnt_nxt = recal_cnt + RECAL_W'(1);
`endif
        end
        S_OPEN: begin
          if (close_cond) state_nxt = S_HOLD;
        end
        S_HOLD: begin
          if (open_cond) state_nxt = S_OPEN;
          else if (close_cond) begin
            if (hold_cnt == HOLD_LAST) state_nxt = S_CLOSED;
            else                       hold_cnt_nxt = hold_cnt + HOLD_W'(1);
          end
        end
        default: state_nxt = S_CAL;
      endcase
    end
    // Any state entry (including a restarted CAL window) starts every counter afresh.
    if (start_cal || (state_nxt != state)) begin
      cal_cnt_nxt  = '0;
      hold_cnt_nxt = '0;
`ifdef SNR_GATE_AUTO_RECAL_EN
      recal_cnt_nxt = '0;
`endif
    end
  end

  always_comb begin
    gate_open_nxt  = (state_nxt == S_OPEN) || (state_nxt == S_HOLD);
    quiet_nxt      = (state_nxt == S_CAL);
    calibrated_nxt = calibrated || ((state == S_CAL) && (state_nxt == S_CLOSED));
    gate_event_nxt = gate_event;
    gate_valid_nxt = gate_valid;
    // A new transition overrides a same-cycle acceptance of the previous event.
    if (gate_open_nxt != gate_open) begin
      gate_event_nxt = gate_open_nxt;
      gate_valid_nxt = 1'b1;
    end else if (gate_valid && gate_ready) begin
      gate_valid_nxt = 1'b0;
    end
  end

endmodule
